lut_mult_seq: RTL



---
 rtl/lut_mult_pkg.sv | 17 +
 rtl/lut_mult_seq_if.sv | 27 ++
 rtl/lut_byte_core.sv | 25 ++
 rtl/lut_mult_seq.sv | 110 +++++++++++
 4 files changed

// File: rtl/lut_mult_pkg.sv
// Shared types and sizing helpers for the byte-serial constant multiplier.
// Imported by the interface, the byte core and the sequencer.
package lut_mult_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned prod_w(input int unsigned w);
      return w + BYTE_W;
   endfunction

endpackage

// File: rtl/lut_mult_seq_if.sv
// Operand/product valid-ready bundle plus busy flag.
// master = producer/consumer side, slave = sequencer side.
interface lut_mult_seq_if
   import lut_mult_pkg::*;
#(
   parameter int unsigned WIDTH = 16
);

   logic                      in_valid;
   logic                      in_ready;
   logic [WIDTH-1:0]          in_x;
   logic                      out_valid;
   logic                      out_ready;
   logic [prod_w(WIDTH)-1:0]  out_p;
   logic                      busy;

   modport master (
      output in_valid, in_x, out_ready,
      input  in_ready, out_valid, out_p, busy
   );

   modport slave (
      input  in_valid, in_x, out_ready,
      output in_ready, out_valid, out_p, busy
   );

endinterface

// File: rtl/lut_byte_core.sv
// Combinational A_CONST*byte from two 16-entry nibble LUTs.
// Result is lo + (hi << 4), always fits in 16 bits.
module lut_byte_core
   import lut_mult_pkg::*;
#(
   parameter int unsigned A_CONST = 2
) (
   input  logic [BYTE_W-1:0] i_b,
   output logic [15:0]       o_p
);

   logic [11:0] w_lut [16];

   for (genvar k = 0; k < 16; k++) begin : g_lut
      assign w_lut[k] = 12'(A_CONST * k);
   end

   logic [15:0] w_lo;
   logic [15:0] w_hi;

   assign w_lo = 16'(w_lut[i_b[3:0]]);
   assign w_hi = 16'(w_lut[i_b[7:4]]) << 4;
   assign o_p  = w_lo + w_hi;

endmodule

// File: rtl/lut_mult_seq.sv
// Byte-serial A_CONST*X sequencer sharing one LUT byte multiplier.
// Define LUT_MULT_SKIP_ZERO_EN to finish early once remaining bytes are zero.
module lut_mult_seq
   import lut_mult_pkg::*;
#(
   parameter int unsigned A_CONST = 2,
   parameter int unsigned WIDTH   = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   lut_mult_seq_if.slave bus
);

   localparam int unsigned NBYTES = WIDTH / BYTE_W;
   localparam int unsigned PW     = prod_w(WIDTH);
   localparam int unsigned CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   if ((WIDTH % BYTE_W) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
      $error("lut_mult_seq: WIDTH must be a multiple of 8 in 8..64");
   end

   state_t          r_state;
   logic [WIDTH-1:0] r_xs;
   logic [PW-1:0]   r_acc;
   logic [CW-1:0]   r_cnt;
   logic [PW-1:0]   r_out_p;
   logic            r_in_ready;
   logic            r_out_valid;
   logic            r_busy;

   logic [15:0]      w_prod;
   logic [CW+2:0]    w_sh;
   logic [PW-1:0]    w_sum;
   logic [WIDTH-1:0] w_xs_nxt;
   logic             w_last;

   lut_byte_core #(
      .A_CONST (A_CONST)
   ) u_core (
      .i_b (r_xs[BYTE_W-1:0]),
      .o_p (w_prod)
   );

   assign w_sh     = {r_cnt, 3'b000};
   assign w_sum    = r_acc + (PW'(w_prod) << w_sh);
   assign w_xs_nxt = r_xs >> BYTE_W;

`ifdef LUT_MULT_SKIP_ZERO_EN
   assign w_last = (r_cnt == CW'(NBYTES - 1)) || (w_xs_nxt == '0);
`else
   assign w_last = (r_cnt == CW'(NBYTES - 1));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_xs        <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_out_p     <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_xs       <= bus.in_x;
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               r_acc <= w_sum;
               r_xs  <= w_xs_nxt;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  r_out_p     <= w_sum;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               // Result stays parked until the consumer takes it.
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_p     = r_out_p;
   assign bus.busy      = r_busy;

endmodule
